rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Sequences one complete transaction on the RTC chip's multiplexed parallel bus (AD[7:0], a_d, cs, rd, wr).
- Each transaction is an address phase followed by a data phase, with programmable setup, pulse, hold and recovery times.
- Sits between the general control FSM (requester: start/busy/done handshake) and the AD tri-state buffer.
- The control FSM issues single register reads/writes and no longer generates bus strobes itself.

Parameters:
- T_SETUP, 2, cycles from driving address/data to strobe assertion (legal 1..2^CNT_W-1).
- T_PULSE, 4, cycles that cs and wr/rd stay low (legal 1..2^CNT_W-1).
- T_HOLD, 2, cycles after strobe release before the phase ends (legal 1..2^CNT_W-1).
- T_GAP, 2, recovery cycles after the data phase (legal 1..2^CNT_W-1).
- CNT_W, 4, width of the phase timer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  transaction request; sampled only in IDLE.
- wr_nrd  in  1  1 = write, 0 = read; captured with start.
- addr  in  8  RTC register address; captured with start.
- wdata  in  8  write data; captured with start.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse when a transaction completes.
- rdata  out  8  last read data; holds its value until the next read.
- ad_out  out  8  value driven onto AD through the tri-state buffer.
- ad_oe  out  1  1 = FPGA drives AD (buffer enable).
- ad_in  in  8  AD value seen from the buffer input path.
- a_d  out  1  0 = address cycle, 1 = data cycle.
- cs  out  1  chip select, active low.
- rd  out  1  read strobe, active low.
- wr  out  1  write strobe, active low.

Behaviour:
- Reset values (asynchronous, applied immediately, including mid-transaction):
  - a_d=1, cs=1, rd=1, wr=1, ad_oe=0, ad_out=0x00.
  - rdata=0x00, busy=0, done=0, state=IDLE, timer=0.
- All outputs are registered. Any parameter value of 0 is treated as 1.
- IDLE: bus idle (a_d=1, cs=rd=wr=1, ad_oe=0).
  - On edge E0 with start=1: capture addr, wdata and wr_nrd, set busy=1, go to ADDR_SETUP.
- Each state lasts exactly its parameter count of cycles, then advances:
  - ADDR_SETUP (T_SETUP): a_d=0, ad_oe=1, ad_out=addr, cs=wr=rd=1.
  - ADDR_PULSE (T_PULSE): a_d=0, ad_oe=1, cs=0, wr=0. The address phase always uses wr.
  - ADDR_HOLD (T_HOLD): a_d=0, ad_oe=1, cs=1, wr=1.
  - DATA_SETUP (T_SETUP): a_d=1, cs=1. Write: ad_oe=1, ad_out=wdata. Read: ad_oe=0.
  - DATA_PULSE (T_PULSE): cs=0. Write: wr=0, ad_oe=1. Read: rd=0, ad_oe=0. On a read, rdata<=ad_in at the edge leaving this state.
  - DATA_HOLD (T_HOLD): cs=1, rd=wr=1. Write: ad_oe stays 1. Read: ad_oe=0.
  - RECOVER (T_GAP): bus idle, ad_oe=0. On exit go to IDLE with busy=0 and done=1 for exactly one cycle.
- Latency:
  - busy is high for N = 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles (18 with defaults).
  - done is high in cycle N+1 after E0.
- start while busy=1 is ignored; it is not queued.
- start=1 in the done cycle (state IDLE) is accepted and begins a new transaction, giving back-to-back operation.
- Invariants, checked every cycle:
  - rd and wr are never low simultaneously.
  - ad_oe=0 whenever rd=0.
  - a_d changes only while cs=1.
  - ad_out changes only while cs=1.
- Captured inputs are held constant for the whole transaction, even if the inputs change.

Test Plan:
- Write, defaults, addr=0x21, wdata=0x45:
  - a_d low for cycles 1-8, strobe cs=wr=0 in cycles 3-6 with ad_out=0x21.
  - cs=wr=0 in cycles 11-14 with ad_out=0x45, ad_oe=1.
  - busy cycles 1-18, done=1 in cycle 19, rd never low.
- Read, defaults, addr=0x22, ad_in=0x37 during the data pulse:
  - rd=0 in cycles 11-14 with ad_oe=0.
  - rdata=0x37 from cycle 15 onward, done in cycle 19.
- start held high continuously:
  - Exactly one transaction per 19 cycles, with no gap between done and the next busy.
  - Mid-transaction start pulses have no effect.
- All parameters set to 1 (timer parameters 0 and 1 both checked):
  - busy for 7 cycles, done in cycle 8.
  - Parameter value 0 produces identical timing to 1.
- Async reset asserted mid DATA_PULSE of a read:
  - Same cycle: cs=rd=wr=a_d=1, ad_oe=0, busy=0.
  - rdata keeps its reset value 0x00; no done pulse.
  - A new start after release completes normally.
- Random addr/wdata/wr_nrd over 1000 transactions, with an assertion monitor for all invariants:
  - Zero violations.
  - Write data on AD matches the captured wdata.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// Sequences one address+data transaction on the RTC multiplexed parallel bus
// with programmable setup/pulse/hold/recovery timing; all outputs registered.
module rtc_bus_sequencer #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_nrd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr
);

  // A programmed duration of 0 behaves as 1; the timer is loaded with duration-1.
  localparam int unsigned SETUP_EFF = (T_SETUP == 0) ? 1 : T_SETUP;
  localparam int unsigned PULSE_EFF = (T_PULSE == 0) ? 1 : T_PULSE;
  localparam int unsigned HOLD_EFF  = (T_HOLD  == 0) ? 1 : T_HOLD;
  localparam int unsigned GAP_EFF   = (T_GAP   == 0) ? 1 : T_GAP;
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_EFF - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_PULSE,
    S_ADDR_HOLD,
    S_DATA_SETUP,
    S_DATA_PULSE,
    S_DATA_HOLD,
    S_RECOVER
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic             op_wr, op_wr_d;
  logic [7:0]       op_addr, op_addr_d;
  logic [7:0]       op_wdata, op_wdata_d;
  logic [7:0]       rdata_d, ad_out_d;
  logic             busy_d, done_d, ad_oe_d, a_d_d, cs_d, rd_d, wr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      op_wr    <= 1'b0;
      op_addr  <= 8'h00;
      op_wdata <= 8'h00;
      rdata    <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      ad_out   <= 8'h00;
      ad_oe    <= 1'b0;
      a_d      <= 1'b1;
      cs       <= 1'b1;
      rd       <= 1'b1;
      wr       <= 1'b1;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      op_wr    <= op_wr_d;
      op_addr  <= op_addr_d;
      op_wdata <= op_wdata_d;
      rdata    <= rdata_d;
      busy     <= busy_d;
      done     <= done_d;
      ad_out   <= ad_out_d;
      ad_oe    <= ad_oe_d;
      a_d      <= a_d_d;
      cs       <= cs_d;
      rd       <= rd_d;
      wr       <= wr_d;
    end
  end

  // Next state/timer, then the bus image of the next state so outputs are registered.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    op_wr_d    = op_wr;
    op_addr_d  = op_addr;
    op_wdata_d = op_wdata;
    rdata_d    = rdata;
    done_d     = 1'b0;

    if (state == S_IDLE) begin
      timer_d = '0;
      if (start) begin
        state_d    = S_ADDR_SETUP;
        timer_d    = LD_SETUP;
        op_wr_d    = wr_nrd;
        op_addr_d  = addr;
        op_wdata_d = wdata;
      end
    end else if (timer != '0) begin
      timer_d = timer - CNT_W'(1);
    end else begin
      case (state)
        S_ADDR_SETUP: begin state_d = S_ADDR_PULSE; timer_d = LD_PULSE; end
        S_ADDR_PULSE: begin state_d = S_ADDR_HOLD;  timer_d = LD_HOLD;  end
        S_ADDR_HOLD:  begin state_d = S_DATA_SETUP; timer_d = LD_SETUP; end
        S_DATA_SETUP: begin state_d = S_DATA_PULSE; timer_d = LD_PULSE; end
        S_DATA_PULSE: begin
          state_d = S_DATA_HOLD;
          timer_d = LD_HOLD;
          if (!op_wr) rdata_d = ad_in;
        end
        S_DATA_HOLD:  begin state_d = S_RECOVER;    timer_d = LD_GAP;   end
        S_RECOVER: begin
          state_d = S_IDLE;
          timer_d = '0;
          done_d  = 1'b1;
        end
        default: begin state_d = S_IDLE; timer_d = '0; end
      endcase
    end

    busy_d   = (state_d != S_IDLE);
    a_d_d    = 1'b1;
    cs_d     = 1'b1;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out;
    // ad_out only moves in setup states, where cs is high on both sides of the edge.
    case (state_d)
      S_ADDR_SETUP: begin a_d_d = 1'b0; ad_oe_d = 1'b1; ad_out_d = op_addr_d; end
      S_ADDR_PULSE: begin a_d_d = 1'b0; ad_oe_d = 1'b1; cs_d = 1'b0; wr_d = 1'b0; end
      S_ADDR_HOLD:  begin a_d_d = 1'b0; ad_oe_d = 1'b1; end
      S_DATA_SETUP: begin
        ad_oe_d = op_wr_d;
        if (op_wr_d) ad_out_d = op_wdata_d;
      end
      S_DATA_PULSE: begin
        cs_d    = 1'b0;
        ad_oe_d = op_wr_d;
        wr_d    = ~op_wr_d;
        rd_d    = op_wr_d;
      end
      S_DATA_HOLD:  ad_oe_d = op_wr_d;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: vector table, scoreboard of
// completed transactions, per-cycle timing and bus invariant checks.
module tb_rtc_bus_sequencer;

  localparam int TS = 2, TP = 4, TH = 2, TG = 2;
  localparam int A_END = TS + TP + TH;
  localparam int N_CYC = 2 * A_END + TG;

  logic       clk = 1'b0;
  logic       reset, start, wr_nrd;
  logic [7:0] addr, wdata, rd_val, ad_in;
  logic       busy, done, ad_oe, a_d, cs, rd, wr;
  logic [7:0] rdata, ad_out;

  logic       o_busy, o_done, o_ad_oe, o_a_d, o_cs, o_rd, o_wr;
  logic [7:0] o_rdata, o_ad_out;
  logic       z_busy, z_done, z_ad_oe, z_a_d, z_cs, z_rd, z_wr;
  logic [7:0] z_rdata, z_ad_out;

  always #5 clk = ~clk;

  // Bus returns rd_val only while rd is low, so a mistimed sample reads garbage.
  assign ad_in = rd ? ~rd_val : rd_val;

  rtc_bus_sequencer #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr));

  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1), .CNT_W(4)) u_one (
    .clk(clk), .reset(reset), .start(start), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(o_busy), .done(o_done), .rdata(o_rdata), .ad_out(o_ad_out), .ad_oe(o_ad_oe),
    .ad_in(8'h00), .a_d(o_a_d), .cs(o_cs), .rd(o_rd), .wr(o_wr));

  rtc_bus_sequencer #(.T_SETUP(0), .T_PULSE(0), .T_HOLD(0), .T_GAP(0), .CNT_W(4)) u_zero (
    .clk(clk), .reset(reset), .start(start), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(z_busy), .done(z_done), .rdata(z_rdata), .ad_out(z_ad_out), .ad_oe(z_ad_oe),
    .ad_in(8'h00), .a_d(z_a_d), .cs(z_cs), .rd(z_rd), .wr(z_wr));

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdv;
    logic [7:0] exp_rdata;
  } vec_t;

  txn_t       sb[$];
  vec_t       vecs[6];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_rd = 8'h00;
  logic       skip_inv = 1'b1;
  logic       p_a_d, p_cs;
  logic [7:0] p_ad_out;
  logic       obs_wr;
  logic [7:0] obs_addr, obs_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {busy,done,a_d,cs,rd,wr,ad_oe} in cycle k after the accepting edge.
  function automatic logic [6:0] exp_bus(input int k, input logic w,
                                         input int ts, input int tp, input int th, input int tg);
    int ae, n;
    logic ap, dp;
    ae = ts + tp + th;
    n  = 2 * ae + tg;
    ap = (k > ts) && (k <= ts + tp);
    dp = (k > ae + ts) && (k <= ae + ts + tp);
    return {k <= n, k == n + 1, !(k <= ae), !(ap || dp), !(dp && !w),
            !(ap || (dp && w)), (k <= ae) || (w && k > ae && k <= 2 * ae)};
  endfunction

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv);
    txn_t t;
    t.wr = w; t.addr = a; t.wdata = d; t.rdata = w ? last_rd : rv;
    sb.push_back(t);
    if (!w) last_rd = rv;
  endtask

  // One clock: sample at the falling edge, check invariants and completed transactions.
  task automatic tick();
    logic viol;
    txn_t e;
    @(negedge clk);
    if (reset || skip_inv) begin
      skip_inv = reset;
    end else begin
      viol = (!rd && !wr) || (!rd && ad_oe) ||
             ((a_d != p_a_d) && !(cs && p_cs)) || ((ad_out != p_ad_out) && !(cs && p_cs));
      chk("invariants", 32'(viol), 32'(0));
    end
    p_a_d = a_d; p_cs = cs; p_ad_out = ad_out;
    if (reset) begin
      obs_wr = 1'b0; obs_addr = 8'h00; obs_wd = 8'h00;
    end else begin
      if (!cs && !a_d) obs_addr = ad_out;
      if (!cs && a_d) begin
        obs_wr = !wr;
        if (!wr) obs_wd = ad_out;
      end
      if (done) begin
        if (sb.size() == 0) chk("sb_unexpected_done", 32'(1), 32'(0));
        else begin
          e = sb.pop_front();
          chk("sb_txn", 32'({obs_wr, obs_addr, obs_wr ? obs_wd : 8'h00, rdata}),
                        32'({e.wr, e.addr, e.wr ? e.wdata : 8'h00, e.rdata}));
        end
        obs_wr = 1'b0; obs_addr = 8'h00; obs_wd = 8'h00;
      end
    end
  endtask

  // Starts a transaction in the current (idle) cycle and checks every cycle up to done.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv);
    start = 1'b1; wr_nrd = w; addr = a; wdata = d; rd_val = rv;
    push(w, a, d, rv);
    for (int k = 1; k <= N_CYC + 1; k++) begin
      tick();
      chk("bus_timing", 32'({busy, done, a_d, cs, rd, wr, ad_oe}), 32'(exp_bus(k, w, TS, TP, TH, TG)));
      if (k <= A_END) chk("ad_addr", 32'(ad_out), 32'(a));
      else if (w && k <= 2 * A_END) chk("ad_wdata", 32'(ad_out), 32'(d));
      if (k <= N_CYC) begin
        start  = (k < N_CYC) && ($urandom_range(0, 1) == 1);
        wr_nrd = 1'($urandom_range(0, 1));
        addr   = 8'($urandom);
        wdata  = 8'($urandom);
      end
    end
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h22, 8'h00, 8'h37, 8'h37};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h11, 8'h37};
    vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'hA5, 8'hA5};
    vecs[4] = '{1'b1, 8'hA5, 8'h5A, 8'h00, 8'hA5};
    vecs[5] = '{1'b0, 8'h3C, 8'h00, 8'hC3, 8'hC3};

    reset = 1'b1; start = 1'b0; wr_nrd = 1'b0; addr = 8'h00; wdata = 8'h00; rd_val = 8'h00;
    tick(); tick();
    chk("reset_ctrl", 32'({a_d, cs, rd, wr, ad_oe, busy, done}), 32'(7'b1111000));
    chk("reset_data", 32'({ad_out, rdata}), 32'(16'h0000));
    #2 reset = 1'b0;
    tick();

    // Table-driven transactions, issued back to back.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdv);
      chk("vec_rdata", 32'(rdata), 32'(vecs[i].exp_rdata));
    end

    // start held high: one transaction per N_CYC+1 cycles, done followed by busy.
    start = 1'b1; wr_nrd = 1'b1; addr = 8'h10; wdata = 8'h80;
    push(1'b1, addr, wdata, 8'h00);
    for (int k = 1; k <= 3 * (N_CYC + 1); k++) begin
      tick();
      chk("held_busy_done", 32'({busy, done}), 32'({k % (N_CYC + 1) != 0, k % (N_CYC + 1) == 0}));
      if (k == 3 * (N_CYC + 1)) start = 1'b0;
      else if (k % (N_CYC + 1) == 0) begin
        addr = 8'(k); wdata = ~8'(k);
        push(1'b1, addr, wdata, 8'h00);
      end
    end
    tick();
    chk("held_release", 32'(busy), 32'(0));

    // Minimum timing: parameters 1 and 0 must both give busy 7 cycles, done in cycle 8.
    for (int k = 0; k < 10; k++) tick();
    start = 1'b1; wr_nrd = 1'b1; addr = 8'h5A; wdata = 8'hA5;
    push(1'b1, addr, wdata, 8'h00);
    for (int k = 1; k <= N_CYC + 1; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k <= 8) begin
        chk("min_one_bus", 32'({o_busy, o_done, o_a_d, o_cs, o_rd, o_wr, o_ad_oe}),
            32'(exp_bus(k, 1'b1, 1, 1, 1, 1)));
        chk("min_zero_bus", 32'({z_busy, z_done, z_a_d, z_cs, z_rd, z_wr, z_ad_oe}),
            32'(exp_bus(k, 1'b1, 1, 1, 1, 1)));
        chk("min_one_ad", 32'({o_ad_out, o_rdata}), 32'({(k <= 3) ? 8'h5A : 8'hA5, 8'h00}));
        chk("min_zero_ad", 32'({z_ad_out, z_rdata}), 32'({(k <= 3) ? 8'h5A : 8'hA5, 8'h00}));
      end
    end

    // Async reset in the middle of a read data pulse.
    start = 1'b1; wr_nrd = 1'b0; addr = 8'h22; rd_val = 8'h99;
    for (int k = 1; k <= A_END + TS + 2; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    chk("rst_pre_pulse", 32'({cs, rd}), 32'(2'b00));
    #2 reset = 1'b1;
    #1;
    chk("rst_async", 32'({cs, rd, wr, a_d, ad_oe, busy, done}), 32'(7'b1111000));
    sb.delete();
    last_rd = 8'h00;
    tick();
    #2 reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(8'h00));
    run_txn(1'b0, 8'h22, 8'h00, 8'h37);
    chk("rst_recover_rdata", 32'(rdata), 32'(8'h37));

    // Random transactions with scrambled inputs while busy.
    for (int i = 0; i < 1000; i++) begin
      logic w;
      logic [7:0] a, d, rv;
      w = 1'($urandom_range(0, 1)); a = 8'($urandom); d = 8'($urandom); rv = 8'($urandom);
      run_txn(w, a, d, rv);
    end
    start = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
